i2c_ctrl: RTL and testbench
===========================

I2C_CTRL -- requirements
Module: i2c_ctrl

Interface
REQ-001 The block SHALL provide parameter DEV_ADDR, default 7'h73, the 7-bit slave address used for every write.
REQ-002 The block SHALL provide parameter CFG_NUM, default 51, the number of configuration writes per power-up sequence.
REQ-003 The block SHALL provide parameter PWR_WAIT, default 1000, the number of i2c_clk cycles of power-up delay before configuration.
REQ-004 Port: i2c_clk  input  1  block clock; SCL runs at i2c_clk/4.
REQ-005 Port: sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: i2c_start  input  1  one-cycle request to start a write of cfg_data.
REQ-007 Port: cfg_data  input  16  [15:8] register address, [7:0] register data.
REQ-008 Port: step  output  3  sequence phase: 0 = power-up wait, 4 = configuring, 5 = done.
REQ-009 Port: cfg_start  output  1  one-cycle request to the word supplier for the next configuration word.
REQ-010 Port: i2c_end  output  1  one-cycle pulse on the last cycle of STOP.
REQ-011 Port: ack_err  output  1  sticky flag: a slave NACK has been seen.
REQ-012 Port: scl  output  1  I2C clock.
REQ-013 Port: sda  inout  1  open-drain I2C data; the block drives only 0 or Z.

Function
REQ-014 Bit timing SHALL use a 2-bit phase counter cnt (0..3) per bit slot.
- scl = 1 at cnt 1 and 2, 0 at cnt 0 and 3, in the address, data and ACK states.
- The SDA drive value SHALL change only at cnt 0.
REQ-015 The FSM SHALL have states IDLE, START, DADDR, ACK1, RADDR, ACK2, WDATA, ACK3, STOP.
- Order is fixed: IDLE->START->DADDR->ACK1->RADDR->ACK2->WDATA->ACK3->STOP->IDLE.
REQ-016 In IDLE, with i2c_start = 1, the block SHALL latch cfg_data and enter START on the next cycle.
- i2c_start outside IDLE SHALL be ignored.
- cfg_data changes after the latch SHALL have no effect on the current transfer.
REQ-017 START SHALL last 4 cycles: scl = 1 throughout; sda released at cnt 0-1, driven 0 at cnt 2-3; scl then falls at DADDR cnt 0.
REQ-018 DADDR, RADDR and WDATA SHALL each last 32 cycles and send MSB first.
- DADDR sends {DEV_ADDR,1'b0} (8'hE6 by default).
- RADDR sends cfg_data[15:8].
- WDATA sends cfg_data[7:0].
- A 1 bit SHALL release sda; a 0 bit SHALL drive it low.
REQ-019 Each ACKn state SHALL last 4 cycles, with sda released.
- sda SHALL be sampled at cnt 2.
- If the sample is 1, ack_err SHALL be set; the transfer SHALL still continue through all remaining states (no abort).
REQ-020 STOP SHALL last 4 cycles: scl = 0 and sda = 0 at cnt 0; scl = 1 at cnt 1-3; sda released at cnt 2-3.
- i2c_end SHALL be 1 at STOP cnt 3 only.
REQ-021 One transaction SHALL take exactly 116 cycles from START entry to IDLE return; IDLE SHALL hold scl = 1 with sda released.
REQ-022 Sequencer behaviour:
- After reset, step = 0 and a counter runs PWR_WAIT cycles.
- The counter then sets step = 4 and pulses cfg_start for 1 cycle.
REQ-023 Each i2c_end while step = 4 SHALL increment the done count (6-bit).
- If the count is below CFG_NUM, cfg_start SHALL pulse on the following cycle.
- When the count reaches CFG_NUM, step SHALL become 5 and no further cfg_start SHALL be issued.
REQ-024 With step = 5 the block SHALL still serve external i2c_start requests but SHALL NOT alter step or the done count.
REQ-025 If i2c_start and i2c_end coincide, i2c_start SHALL be ignored, because the FSM is not in IDLE.

Reset
REQ-026 On sys_rst_n = 0, the block SHALL immediately force the following, including mid-transfer:
- FSM to IDLE, cnt to 0;
- scl to 1, sda released;
- step, cfg_start, i2c_end, ack_err and the done count to 0;
- the power-up counter restarted.

Verification
REQ-027 Reset, then hold for PWR_WAIT = 1000 cycles -> step goes 0 to 4 at cycle 1000; cfg_start pulses once; scl stays 1 and sda stays Z.
REQ-028 i2c_start with cfg_data = 16'h3707 and the slave ACKing -> bus shows START, 0xE6, ACK, 0x37, ACK, 0x07, ACK, STOP; i2c_end occurs at cycle 115 after START entry; ack_err = 0.
REQ-029 The slave NACKs the RADDR byte -> ack_err = 1; WDATA and STOP still complete; ack_err stays 1 until reset.
REQ-030 Run the full sequence with a model word supplier -> exactly 51 transactions and 51 cfg_start pulses, then step = 5; an extra i2c_start produces a 116-cycle write with step still 5.
REQ-031 Assert reset at DADDR bit 3 -> scl = 1 and sda = Z within the same cycle; after release, the power-up wait restarts and step = 0.
REQ-032 i2c_start is pulsed during WDATA -> it is ignored, the transfer proceeds unchanged, and no second transaction starts.

Source files
------------

// File: rtl/i2c_ctrl.sv
// I2C configuration write controller: after a power-up delay it requests CFG_NUM
// register writes and performs each as START, {DEV_ADDR,W}, reg addr, reg data, STOP.
module i2c_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h73,
    parameter int         CFG_NUM  = 51,
    parameter int         PWR_WAIT = 1000
) (
    input  logic        i2c_clk,
    input  logic        sys_rst_n,
    input  logic        i2c_start,
    input  logic [15:0] cfg_data,
    output logic [2:0]  step,
    output logic        cfg_start,
    output logic        i2c_end,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] DADDR = 4'd2;
    localparam logic [3:0] ACK1  = 4'd3;
    localparam logic [3:0] RADDR = 4'd4;
    localparam logic [3:0] ACK2  = 4'd5;
    localparam logic [3:0] WDATA = 4'd6;
    localparam logic [3:0] ACK3  = 4'd7;
    localparam logic [3:0] STOP  = 4'd8;

    localparam logic [2:0] STEP_WAIT = 3'd0;
    localparam logic [2:0] STEP_CFG  = 3'd4;
    localparam logic [2:0] STEP_DONE = 3'd5;

    localparam int               PWR_W    = (PWR_WAIT > 1) ? $clog2(PWR_WAIT) : 1;
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_WAIT - 1);
    localparam logic [5:0]       CFG_LAST = 6'(CFG_NUM - 1);

    logic [3:0]       state;
    logic [3:0]       next_state;
    logic [1:0]       cnt;
    logic [2:0]       bit_cnt;
    logic [15:0]      cfg_lat;
    logic [7:0]       tx_byte;
    logic             tx_bit;
    logic             is_byte;
    logic             is_ack;
    logic             sda_oe;
    logic             sda_in;
    logic [PWR_W-1:0] pwr_cnt;
    logic [5:0]       done_cnt;

    assign is_byte    = (state == DADDR) || (state == RADDR) || (state == WDATA);
    assign is_ack     = (state == ACK1) || (state == ACK2) || (state == ACK3);
    assign next_state = (state == STOP) ? IDLE : state + 4'd1;
    assign i2c_end    = (state == STOP) && (cnt == 2'd3);

    // Open-drain pad: only ever pull low or release.
    assign sda    = sda_oe ? 1'b0 : 1'bz;
    assign sda_in = sda;

    always_comb begin
        tx_byte = 8'hFF;
        case (state)
            DADDR:   tx_byte = {DEV_ADDR, 1'b0};
            RADDR:   tx_byte = cfg_lat[15:8];
            WDATA:   tx_byte = cfg_lat[7:0];
            default: tx_byte = 8'hFF;
        endcase
    end

    assign tx_bit = tx_byte[3'd7 - bit_cnt];

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state)
            IDLE: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
            START: begin
                scl    = 1'b1;
                sda_oe = cnt[1];
            end
            STOP: begin
                // SDA rises while SCL is high at cnt 2 to form the STOP condition.
                scl    = (cnt != 2'd0);
                sda_oe = !cnt[1];
            end
            default: begin
                scl    = (cnt == 2'd1) || (cnt == 2'd2);
                sda_oe = is_byte && !tx_bit;
            end
        endcase
    end

    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            bit_cnt <= 3'd0;
            ack_err <= 1'b0;
        end else if (state == IDLE) begin
            cnt     <= 2'd0;
            bit_cnt <= 3'd0;
            if (i2c_start) begin
                state <= START;
            end
        end else begin
            cnt <= cnt + 2'd1;
            if (is_ack && (cnt == 2'd2) && sda_in) begin
                ack_err <= 1'b1;
            end
            if (cnt == 2'd3) begin
                if (is_byte) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= next_state;
                    end
                end else begin
                    state <= next_state;
                end
            end
        end
    end

    always_ff @(posedge i2c_clk) begin
        if ((state == IDLE) && i2c_start) begin
            cfg_lat <= cfg_data;
        end
    end

    // Sequencer: power-up delay, then one cfg_start per completed write until CFG_NUM.
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            step      <= STEP_WAIT;
            cfg_start <= 1'b0;
            pwr_cnt   <= '0;
            done_cnt  <= 6'd0;
        end else begin
            cfg_start <= 1'b0;
            if (step == STEP_WAIT) begin
                if (pwr_cnt == PWR_LAST) begin
                    step      <= STEP_CFG;
                    cfg_start <= 1'b1;
                end else begin
                    pwr_cnt <= pwr_cnt + 1'b1;
                end
            end else if ((step == STEP_CFG) && i2c_end) begin
                done_cnt <= done_cnt + 6'd1;
                if (done_cnt == CFG_LAST) begin
                    step <= STEP_DONE;
                end else begin
                    cfg_start <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_ctrl.sv
// Bench for i2c_ctrl: bus-level monitor with an ACK/NACK slave, scoreboard of
// expected transfers, table of single-write vectors and multi-cycle corner cases.
module tb_i2c_ctrl;
    logic        i2c_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        i2c_start = 1'b0;
    logic [15:0] cfg_data  = 16'h0000;
    logic [2:0]  step;
    logic        cfg_start;
    logic        i2c_end;
    logic        ack_err;
    logic        scl;
    wire         sda;

    logic        slv_drive = 1'b0;
    logic [2:0]  nack_mask = 3'b000;

    assign sda = slv_drive ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_ctrl dut (
        .i2c_clk   (i2c_clk),
        .sys_rst_n (sys_rst_n),
        .i2c_start (i2c_start),
        .cfg_data  (cfg_data),
        .step      (step),
        .cfg_start (cfg_start),
        .i2c_end   (i2c_end),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 i2c_clk = ~i2c_clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];

    logic [7:0]  mon_bytes[3];
    int          mon_nbytes = 0;
    logic        mon_active = 1'b0;
    int          mon_stops  = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  nack;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_scl(input int t);
        if (t < 4) return 1'b1;
        if (t >= 112) return (t != 112);
        return ((t % 4) == 1) || ((t % 4) == 2);
    endfunction

    function automatic logic [15:0] cfg_word(input int i);
        return {8'(i * 5 + 17), 8'(i ^ 8'hA0)};
    endfunction

    // Bus monitor and slave: decodes START/bytes/STOP and answers each ACK slot.
    initial begin : monitor
        logic       ps;
        logic       pd;
        int         bitpos;
        logic [7:0] sh;
        ps = 1'b1; pd = 1'b1; bitpos = 0; sh = 8'h00;
        forever begin
            @(negedge i2c_clk);
            if (!sys_rst_n) begin
                mon_active = 1'b0; bitpos = 0; slv_drive = 1'b0;
            end else if (scl && ps && pd && !sda) begin
                mon_active = 1'b1; mon_nbytes = 0; bitpos = 0;
            end else if (scl && ps && !pd && sda && mon_active) begin
                mon_active = 1'b0; mon_stops++; slv_drive = 1'b0;
            end else if (mon_active) begin
                if (scl && !ps) begin
                    if (bitpos < 8) begin
                        sh = {sh[6:0], sda}; bitpos++;
                    end else begin
                        if (mon_nbytes < 3) mon_bytes[mon_nbytes] = sh;
                        mon_nbytes++; bitpos = 0;
                    end
                end else if (!scl && ps) begin
                    if (bitpos == 8 && mon_nbytes < 3) slv_drive = !nack_mask[mon_nbytes];
                    else slv_drive = 1'b0;
                end
            end
            ps = scl; pd = sda;
        end
    end

    task automatic compare_txn();
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL txn: got a transfer, expected none queued");
            return;
        end
        e = exp_q.pop_front();
        check("txn bus bytes",
              {5'd0, mon_active, (mon_nbytes == 3), mon_bytes[0], mon_bytes[1], mon_bytes[2]},
              {5'd0, 1'b0, 1'b1, e});
    endtask

    task automatic do_xfer(input logic [15:0] d, input logic [2:0] nack, input int glitch_t);
        int t;
        int scl_bad;
        @(negedge i2c_clk);
        cfg_data = d; nack_mask = nack; i2c_start = 1'b1;
        exp_q.push_back({8'hE6, d});
        @(negedge i2c_clk);
        i2c_start = 1'b0; cfg_data = ~d;
        t = 0; scl_bad = 0;
        while (t < 200) begin
            if (t == glitch_t) begin
                i2c_start = 1'b1; cfg_data = 16'hDEAD;
            end else begin
                i2c_start = 1'b0;
            end
            if (scl !== exp_scl(t)) scl_bad++;
            if (i2c_end) break;
            @(negedge i2c_clk);
            t++;
        end
        @(negedge i2c_clk);
        i2c_start = 1'b0;
        check("xfer end cycle", t, 115);
        check("xfer scl shape", scl_bad, 0);
        compare_txn();
    endtask

    task automatic pwr_check(input string tag);
        int cyc;
        int idle_bad;
        int starts;
        cyc = 0; idle_bad = 0; starts = 0;
        while (step == 3'd0 && cyc < 1100) begin
            @(negedge i2c_clk);
            cyc++;
            if (scl !== 1'b1 || sda !== 1'b1) idle_bad++;
            if (cfg_start) starts++;
        end
        check({tag, " step"}, step, 4);
        check({tag, " cycles"}, cyc, 1000);
        check({tag, " cfg_start"}, starts, 1);
        check({tag, " idle bus"}, idle_bad, 0);
    endtask

    task automatic pulse_reset();
        @(negedge i2c_clk);
        sys_rst_n = 1'b0;
        @(negedge i2c_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic quiet_check(input string tag);
        int ends;
        int stops0;
        ends = 0; stops0 = mon_stops;
        repeat (150) begin
            @(negedge i2c_clk);
            if (i2c_end) ends++;
        end
        check({tag, " extra i2c_end"}, ends, 0);
        check({tag, " extra STOP"}, mon_stops - stops0, 0);
        check({tag, " queue empty"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n_cfg;
        int n_end;
        int k;
        int extra;

        vecs[0] = '{data: 16'h3707, nack: 3'b000, exp_err: 1'b0};
        vecs[1] = '{data: 16'h0000, nack: 3'b000, exp_err: 1'b0};
        vecs[2] = '{data: 16'hFFFF, nack: 3'b000, exp_err: 1'b0};
        vecs[3] = '{data: 16'h8001, nack: 3'b000, exp_err: 1'b0};
        vecs[4] = '{data: 16'h1234, nack: 3'b010, exp_err: 1'b1};
        vecs[5] = '{data: 16'hC3A5, nack: 3'b001, exp_err: 1'b1};
        vecs[6] = '{data: 16'h5AA5, nack: 3'b100, exp_err: 1'b1};

        repeat (3) @(negedge i2c_clk);
        check("reset step", step, 0);
        check("reset scl", scl, 1);
        check("reset sda", sda, 1);
        check("reset cfg_start", cfg_start, 0);
        check("reset i2c_end", i2c_end, 0);
        check("reset ack_err", ack_err, 0);

        sys_rst_n = 1'b1;
        pwr_check("powerup");

        // Word supplier answers every cfg_start with a one-cycle i2c_start.
        n_cfg = 0; n_end = 0; k = 0;
        for (int c = 0; c < 8000 && step != 3'd5; c++) begin
            if (cfg_start) begin
                n_cfg++;
                cfg_data = cfg_word(k); i2c_start = 1'b1;
                exp_q.push_back({8'hE6, cfg_word(k)});
                k++;
            end else begin
                i2c_start = 1'b0;
            end
            if (i2c_end) begin
                n_end++;
                compare_txn();
            end
            @(negedge i2c_clk);
        end
        i2c_start = 1'b0;
        check("seq step done", step, 5);
        check("seq cfg_start count", n_cfg, 51);
        check("seq i2c_end count", n_end, 51);
        check("seq ack_err", ack_err, 0);

        extra = 0;
        repeat (200) begin
            @(negedge i2c_clk);
            if (cfg_start) extra++;
        end
        check("done no cfg_start", extra, 0);
        do_xfer(16'hA55A, 3'b000, -1);
        check("done step after xfer", step, 5);

        for (int i = 0; i < 7; i++) begin
            pulse_reset();
            check("vec ack_err cleared", ack_err, 0);
            do_xfer(vecs[i].data, vecs[i].nack, -1);
            check("vec ack_err", ack_err, vecs[i].exp_err);
            repeat (50) @(negedge i2c_clk);
            check("vec ack_err sticky", ack_err, vecs[i].exp_err);
            check("vec step", step, 0);
        end

        pulse_reset();
        do_xfer(16'h4C21, 3'b000, 80);
        quiet_check("start in WDATA");
        do_xfer(16'h0F3C, 3'b000, 115);
        quiet_check("start at i2c_end");

        // Reset landing in DADDR bit 3 (a 0 bit, so SDA is being pulled low).
        pulse_reset();
        @(negedge i2c_clk);
        cfg_data = 16'h3707; i2c_start = 1'b1;
        @(negedge i2c_clk);
        i2c_start = 1'b0;
        repeat (16) @(negedge i2c_clk);
        check("pre-reset scl", scl, 0);
        check("pre-reset sda", sda, 0);
        sys_rst_n = 1'b0;
        #1;
        check("async reset scl", scl, 1);
        check("async reset sda", sda, 1);
        check("async reset step", step, 0);
        check("async reset i2c_end", i2c_end, 0);
        @(negedge i2c_clk);
        sys_rst_n = 1'b1;
        pwr_check("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
